// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan constants and the prefix-tracking state type.
package ps2_pkg;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_BRK,
    PS_EXT,
    PS_EXT_BRK
  } prefix_e;
endpackage

// File: rtl/scan_to_ascii.sv
// Combinational set-2 make-code to ASCII lookup with shift / caps-lock casing.
module scan_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ch,
  output logic       hit
);
  logic [7:0] lo, hi;
  logic       letter;

  always_comb begin
    lo  = 8'h00;
    hi  = 8'h00;
    hit = 1'b1;
    case (code)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h16: begin lo = "1";  hi = "!";  end
      8'h1E: begin lo = "2";  hi = "@";  end
      8'h26: begin lo = "3";  hi = "#";  end
      8'h25: begin lo = "4";  hi = "$";  end
      8'h2E: begin lo = "5";  hi = "%";  end
      8'h36: begin lo = "6";  hi = "^";  end
      8'h3D: begin lo = "7";  hi = "&";  end
      8'h3E: begin lo = "8";  hi = "*";  end
      8'h46: begin lo = "9";  hi = "(";  end
      8'h45: begin lo = "0";  hi = ")";  end
      8'h4E: begin lo = "-";  hi = "_";  end
      8'h55: begin lo = "=";  hi = "+";  end
      8'h54: begin lo = "[";  hi = "{";  end
      8'h5B: begin lo = "]";  hi = "}";  end
      8'h4C: begin lo = ";";  hi = ":";  end
      8'h52: begin lo = "'";  hi = "\""; end
      8'h41: begin lo = ",";  hi = "<";  end
      8'h49: begin lo = ".";  hi = ">";  end
      8'h4A: begin lo = "/";  hi = "?";  end
      8'h0E: begin lo = 8'h60; hi = "~";  end
      8'h5D: begin lo = "\\"; hi = "|";  end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      default: hit = 1'b0;
    endcase
  end

  // Unshifted punctuation all sits below 'a', so the range test isolates letters.
  assign letter = (lo >= 8'h61) && (lo <= 8'h7A);
  assign ch     = letter ? ((shift ^ caps) ? (lo - 8'h20) : lo)
                         : (shift ? hi : lo);
endmodule

// File: rtl/scan_code_decoder.sv
// PS/2 set-2 scan byte decoder: prefix/modifier tracking, ASCII lookup, output FIFO.
module scan_code_decoder
  import ps2_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_val,
  output logic [7:0] ascii,
  output logic       ascii_val,
  input  logic       ascii_rdy,
  output logic       overflow
);
  localparam int AW = $clog2(p_depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(p_depth);

  prefix_e    state, state_nxt;
  logic       lshift, rshift, caps;
  logic       lshift_nxt, rshift_nxt, caps_nxt;
  logic       make;
  logic [7:0] map_ch;
  logic       map_hit;
  logic       push_pend;
  logic [7:0] push_char;

  logic [7:0]    mem [p_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  scan_to_ascii u_map (
    .code  (scan_code),
    .shift (lshift | rshift),
    .caps  (caps),
    .ch    (map_ch),
    .hit   (map_hit)
  );

  always_comb begin
    state_nxt  = state;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    caps_nxt   = caps;
    make       = 1'b0;
    if (scan_val) begin
      case (state)
        PS_IDLE: begin
          if (scan_code == SC_BREAK)      state_nxt = PS_BRK;
          else if (scan_code == SC_EXT)   state_nxt = PS_EXT;
          else if (scan_code == SC_LSHIFT) lshift_nxt = 1'b1;
          else if (scan_code == SC_RSHIFT) rshift_nxt = 1'b1;
          else if (scan_code == SC_CAPS)   caps_nxt   = ~caps;
          else                             make       = 1'b1;
        end
        PS_BRK: begin
          if (scan_code == SC_LSHIFT)      lshift_nxt = 1'b0;
          else if (scan_code == SC_RSHIFT) rshift_nxt = 1'b0;
          state_nxt = PS_IDLE;
        end
        PS_EXT:     state_nxt = (scan_code == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
        PS_EXT_BRK: state_nxt = PS_IDLE;
        default:    state_nxt = PS_IDLE;
      endcase
    end
  end

  // Lookup is registered once so the FIFO write is decoupled from the scan path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PS_IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps      <= 1'b0;
      push_pend <= 1'b0;
      push_char <= 8'h00;
    end else begin
      state     <= state_nxt;
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      caps      <= caps_nxt;
      push_pend <= make & map_hit;
      push_char <= map_ch;
    end
  end

  assign ascii_val = (count != '0);
  assign ascii     = mem[rd_ptr];
  assign full      = (count == FULL_CNT);
  assign pop       = ascii_val & ascii_rdy;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign wr_en     = push_pend & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < p_depth; i++) mem[i] <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_char;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_pend & full & ~pop) overflow <= 1'b1;
    end
  end
endmodule
